// File: rtl/pi_digit_streamer.sv
// Converts a binary fixed-point value into a stream of decimal digits (integer digit first),
// handed out over valid/ready with a matching 7-segment pattern.
module pi_digit_streamer #(
    parameter int unsigned NBITS     = 50,
    parameter int unsigned FRAC_BITS = 48,
    parameter int unsigned NDIGITS   = 12
) (
    input  logic             clk_2,
    input  logic             reset_n,
    input  logic             start,
    input  logic [NBITS-1:0] value,
    output logic             busy,
    output logic             digit_valid,
    input  logic             digit_ready,
    output logic [3:0]       digit,
    output logic [3:0]       digit_idx,
    output logic             digit_is_int,
    output logic             done,
    output logic [7:0]       SEG
);

    localparam int unsigned PW = FRAC_BITS + 4;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        DONE
    } state_t;

    state_t               state_q;
    logic [FRAC_BITS-1:0] frac_q;
    logic [3:0]           digit_q;
    logic [3:0]           digit_idx_q;
    logic                 digit_is_int_q;
    logic                 digit_valid_q;
    logic                 busy_q;
    logic                 done_q;
    logic [7:0]           seg_q;

    logic [PW-1:0]        prod_d;
    logic [3:0]           next_digit_d;
    logic [FRAC_BITS-1:0] next_frac_d;
    logic [3:0]           int_digit_d;
    logic                 accept_c;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // frac*10 as shift-and-add; the top four bits are the next decimal digit
    always_comb begin
        prod_d       = (PW'(frac_q) << 3) + (PW'(frac_q) << 1);
        next_digit_d = prod_d[PW-1:FRAC_BITS];
        next_frac_d  = prod_d[FRAC_BITS-1:0];
        int_digit_d  = 4'(value[NBITS-1:FRAC_BITS]);
        accept_c     = digit_valid_q && digit_ready;
    end

    always_ff @(posedge clk_2) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            frac_q         <= '0;
            digit_q        <= '0;
            digit_idx_q    <= '0;
            digit_is_int_q <= 1'b0;
            digit_valid_q  <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            seg_q          <= 8'h00;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        frac_q         <= value[FRAC_BITS-1:0];
                        digit_q        <= int_digit_d;
                        digit_idx_q    <= '0;
                        digit_is_int_q <= 1'b1;
                        digit_valid_q  <= 1'b1;
                        busy_q         <= 1'b1;
                        seg_q          <= {1'b1, seg7(int_digit_d)};
                        state_q        <= EMIT;
                    end
                end
                EMIT: begin
                    if (accept_c) begin
                        if (digit_idx_q == 4'(NDIGITS)) begin
                            digit_valid_q <= 1'b0;
                            busy_q        <= 1'b0;
                            done_q        <= 1'b1;
                            state_q       <= DONE;
                        end else begin
                            digit_q        <= next_digit_d;
                            frac_q         <= next_frac_d;
                            digit_idx_q    <= digit_idx_q + 4'd1;
                            digit_is_int_q <= 1'b0;
                            seg_q          <= {1'b0, seg7(next_digit_d)};
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign digit_valid  = digit_valid_q;
    assign digit        = digit_q;
    assign digit_idx    = digit_idx_q;
    assign digit_is_int = digit_is_int_q;
    assign done         = done_q;
    assign SEG          = seg_q;

endmodule

// File: tb/tb_pi_digit_streamer.sv
// Directed bench for pi_digit_streamer: known values, backpressure, start while busy, mid-stream reset.
module tb_pi_digit_streamer;

    logic        clk_2 = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [49:0] value = '0;
    logic        digit_ready = 1'b1;
    logic        busy, digit_valid, digit_is_int, done;
    logic [3:0]  digit, digit_idx;
    logic [7:0]  SEG;

    int n_checks = 0;
    int n_pass   = 0;

    int pi_d  [13] = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3, 5, 8, 9};
    int one_d [13] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int half_d[13] = '{0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int max_d [13] = '{3, 9, 9, 9, 9, 9, 9, 9, 9, 9, 9, 9, 9};
    logic [6:0] seg_tab[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    pi_digit_streamer dut (
        .clk_2       (clk_2),
        .reset_n     (reset_n),
        .start       (start),
        .value       (value),
        .busy        (busy),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .digit       (digit),
        .digit_idx   (digit_idx),
        .digit_is_int(digit_is_int),
        .done        (done),
        .SEG         (SEG)
    );

    always #5 clk_2 = ~clk_2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".valid"}, 64'(digit_valid), 64'(0));
        check({tag, ".busy"},  64'(busy),        64'(0));
        check({tag, ".digit"}, 64'(digit),       64'(0));
        check({tag, ".idx"},   64'(digit_idx),   64'(0));
        check({tag, ".isint"}, 64'(digit_is_int), 64'(0));
        check({tag, ".done"},  64'(done),        64'(0));
        check({tag, ".seg"},   64'(SEG),         64'(8'h00));
    endtask

    // Called at a negedge while IDLE; returns at the negedge where idx 0 is presented.
    task automatic start_conv(input logic [49:0] v);
        value = v;
        start = 1'b1;
        @(negedge clk_2);
        start = 1'b0;
    endtask

    // Walks the 13-digit stream from idx 0 up to and including the done cycle.
    task automatic expect_stream(input string name, input int e[13], input int stall_at,
                                 input int stall_len, input int poke_at);
        int cycles = 0;
        logic [7:0] es;
        for (int k = 0; k < 13; k++) begin
            es = {(k == 0), seg_tab[e[k]]};
            check($sformatf("%s.valid%0d", name, k), 64'(digit_valid), 64'(1));
            check($sformatf("%s.idx%0d", name, k),   64'(digit_idx),   64'(k));
            check($sformatf("%s.digit%0d", name, k), 64'(digit),       64'(e[k]));
            check($sformatf("%s.isint%0d", name, k), 64'(digit_is_int), 64'(k == 0));
            check($sformatf("%s.seg%0d", name, k),   64'(SEG),         64'(es));
            check($sformatf("%s.busy%0d", name, k),  64'(busy),        64'(1));
            if (k == stall_at) begin
                digit_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk_2);
                    cycles++;
                    check($sformatf("%s.hold_digit%0d", name, s), 64'(digit),     64'(e[k]));
                    check($sformatf("%s.hold_idx%0d", name, s),   64'(digit_idx), 64'(k));
                    check($sformatf("%s.hold_seg%0d", name, s),   64'(SEG),       64'(es));
                    check($sformatf("%s.hold_vld%0d", name, s),   64'(digit_valid), 64'(1));
                end
                digit_ready = 1'b1;
            end
            if (k == poke_at) begin
                start = 1'b1;
                value = 50'h1000000000000;
            end
            @(negedge clk_2);
            cycles++;
            start = 1'b0;
        end
        check({name, ".done"},    64'(done),        64'(1));
        check({name, ".busy_dn"}, 64'(busy),        64'(0));
        check({name, ".vld_dn"},  64'(digit_valid), 64'(0));
        check({name, ".seg_hold"}, 64'(SEG), 64'({1'b0, seg_tab[e[12]]}));
        check({name, ".latency"}, 64'(cycles), 64'(13 + stall_len));
    endtask

    initial begin
        bit saw_done;

        repeat (2) @(negedge clk_2);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk_2);

        start_conv(50'h3243F6A8885A3);
        expect_stream("pi", pi_d, -1, 0, -1);
        @(negedge clk_2);
        check("pi.done_pulse", 64'(done), 64'(0));

        start_conv(50'h1000000000000);
        expect_stream("one", one_d, -1, 0, -1);
        @(negedge clk_2);

        start_conv(50'h0800000000000);
        expect_stream("half", half_d, -1, 0, -1);
        @(negedge clk_2);

        start_conv({50{1'b1}});
        expect_stream("max", max_d, -1, 0, -1);
        @(negedge clk_2);

        // backpressure at idx 4, start poke at idx 6, then start in the DONE cycle
        start_conv(50'h3243F6A8885A3);
        expect_stream("bp", pi_d, 4, 3, 6);
        start = 1'b1;
        value = 50'h0800000000000;
        @(negedge clk_2);
        check("done_start.ignored", 64'(digit_valid), 64'(0));
        check("done_start.busy",    64'(busy),        64'(0));
        @(negedge clk_2);
        start = 1'b0;
        expect_stream("late", half_d, -1, 0, -1);
        @(negedge clk_2);

        // reset while idx 7 is presented
        start_conv(50'h3243F6A8885A3);
        repeat (7) @(negedge clk_2);
        check("rst.idx_before", 64'(digit_idx), 64'(7));
        check("rst.digit_before", 64'(digit), 64'(pi_d[7]));
        reset_n = 1'b0;
        @(negedge clk_2);
        check_reset_outputs("midrst");
        reset_n = 1'b1;
        saw_done = 1'b0;
        repeat (15) begin
            @(negedge clk_2);
            if (done) saw_done = 1'b1;
        end
        check("midrst.no_done", 64'(saw_done), 64'(0));
        check("midrst.idle_vld", 64'(digit_valid), 64'(0));

        start_conv({50{1'b1}});
        expect_stream("post", max_d, -1, 0, -1);
        @(negedge clk_2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
